// File: rtl/display_scan_mux.sv
// -----------------------------------------------------------------------------
// display_scan_mux
//   Self-scanning digit multiplexer for a multiplexed 7-segment display.
//   Rotates an active-low one-hot digit select across NUM_DIGITS positions and
//   drives the BCD code of the digit shown in the current slot. The displayed
//   bank and window are switched only at frame boundaries. The edited digit
//   pair can be blinked.
//
//   Optional feature (compile-time macro LEADING_ZERO_BLANK_EN):
//     defined   -> the top slot is blanked when its digit is 0 (" 9:30").
//     undefined -> digits are only blanked by blinking.
//
// Ports
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   time_bus  : packed BCD banks; bank b digit d at [(b*DIGITS_PER_BANK+d)*4 +: 4]
//   bank_sel  : bank to display (out-of-range values show bank 0)
//   show_in   : 0 = upper window (hour:min), 1 = window from digit 0 (min:sec)
//   edit_en   : blink enable
//   edit_pair : digit pair to blink (pair p = digits 2p, 2p+1)
//   sel       : active-low one-hot digit enable, all ones = dark
//   hex_out   : BCD code for the enabled digit, 4'hF when blanked
// -----------------------------------------------------------------------------
module display_scan_mux #(
  parameter int NUM_DIGITS      = 4,
  parameter int DIGITS_PER_BANK = 6,
  parameter int NUM_BANKS       = 2,
  parameter int SCAN_DIV        = 100000,
  parameter int BLINK_DIV       = 256,
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int PW = (DIGITS_PER_BANK / 2 > 1) ? $clog2(DIGITS_PER_BANK / 2) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_BANKS*DIGITS_PER_BANK*4-1:0] time_bus,
  input  logic [BW-1:0]                          bank_sel,
  input  logic                                   show_in,
  input  logic                                   edit_en,
  input  logic [PW-1:0]                          edit_pair,
  output logic [NUM_DIGITS-1:0]                  sel,
  output logic [3:0]                             hex_out
);

  localparam int IW      = $clog2(NUM_DIGITS);
  localparam int DW      = $clog2(DIGITS_PER_BANK);
  localparam int SW      = $clog2(SCAN_DIV);
  localparam int CW      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int BASE_HI = DIGITS_PER_BANK - NUM_DIGITS;

  logic [SW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic [CW-1:0]         r_blink_cnt;
  logic                  r_blink_phase;
  logic [BW-1:0]         r_bank;
  logic                  r_show;
  logic [NUM_DIGITS-1:0] r_sel;
  logic [3:0]            r_hex;

  logic                  w_tick;
  logic                  w_wrap;
  logic                  w_blink_wrap;
  logic                  w_phase_nxt;
  logic [IW-1:0]         w_idx_nxt;
  logic [CW-1:0]         w_blink_cnt_nxt;
  logic [BW-1:0]         w_bank_use;
  logic                  w_show_use;
  logic [DW-1:0]         w_dig;
  logic [3:0]            w_fetch;
  logic                  w_blank;
  logic [NUM_DIGITS-1:0] w_sel_nxt;
  logic [3:0]            w_hex_nxt;

  // Unpack the bus into a bank/digit array so the fetch is a plain 2-D index.
  logic [3:0] w_digit [NUM_BANKS][DIGITS_PER_BANK];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    for (genvar d = 0; d < DIGITS_PER_BANK; d++) begin : g_dig
      assign w_digit[b][d] = time_bus[(b*DIGITS_PER_BANK+d)*4 +: 4];
    end
  end

  // Everything below describes the slot that starts at the next tick; it is
  // only consumed by the register stage when w_tick is high.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    w_tick          = (r_presc == SW'(SCAN_DIV - 1));
    w_wrap          = (r_idx == IW'(NUM_DIGITS - 1));
    w_idx_nxt       = w_wrap ? '0 : r_idx + 1'b1;
    w_blink_wrap    = (r_blink_cnt == CW'(BLINK_DIV - 1));
    w_blink_cnt_nxt = w_blink_wrap ? '0 : r_blink_cnt + 1'b1;
    w_phase_nxt     = r_blink_phase ^ w_blink_wrap;
    w_bank_use      = r_bank;
    w_show_use      = r_show;

    // At a frame boundary the new idx=0 slot already uses the freshly
    // sampled bank/window, so they bypass the latches here.
    if (w_wrap) begin
      w_bank_use = (32'(bank_sel) < NUM_BANKS) ? bank_sel : '0;
      w_show_use = show_in;
    end

    w_dig   = (w_show_use ? '0 : DW'(BASE_HI)) + DW'(w_idx_nxt);
    w_fetch = w_digit[w_bank_use][w_dig];

    // Pair membership: digit d belongs to pair d/2. Pairs outside the window
    // never match any visible digit, so they blank nothing.
    w_blank = edit_en && w_phase_nxt && ((32'(w_dig) >> 1) == 32'(edit_pair));
`ifdef LEADING_ZERO_BLANK_EN
    if ((w_idx_nxt == IW'(NUM_DIGITS - 1)) && (w_fetch == 4'h0)) begin
      w_blank = 1'b1;
    end
`endif

    w_sel_nxt = w_blank ? '1 : ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << w_idx_nxt);
    w_hex_nxt = w_blank ? 4'hF : w_fetch;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc       <= '0;
      r_idx         <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_bank        <= '0;
      r_show        <= 1'b0;
      r_sel         <= '1;
      r_hex         <= 4'h0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, regardless of statement order.
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_idx         <= w_idx_nxt;
        r_blink_cnt   <= w_blink_cnt_nxt;
        r_blink_phase <= w_phase_nxt;
        r_bank        <= w_bank_use;
        r_show        <= w_show_use;
        // sel and hex_out load on the same edge so the decoder never sees a
        // mixed select/code combination.
        r_sel         <= w_sel_nxt;
        r_hex         <= w_hex_nxt;
      end
    end
  end

  assign sel     = r_sel;
  assign hex_out = r_hex;

endmodule
